// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares the single mapper memory bus between NM masters.
// Define ARB_TIMEOUT_EN to abort a stalled WAIT after TIMEOUT_CYC cycles with an error.
module bus_arbiter #(
  parameter int NM          = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NM-1:0]    m_req,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*32-1:0] m_a,
  input  logic [NM*32-1:0] m_d,
  output logic [NM-1:0]    m_ack,
  output logic [NM-1:0]    m_err,
  output logic [31:0]      m_rdata,
  output logic [31:0]      bus_a,
  output logic [31:0]      bus_d,
  output logic             bus_we,
  output logic             bus_rd,
  input  logic [31:0]      bus_spo,
  input  logic             bus_ready,
  input  logic             bus_irq,
  output logic             busy
);

  localparam int PW = (NM > 2) ? 2 : 1;

  // Parameter range guard: an out-of-range build elaborates this empty marker block.
  if (NM < 2 || NM > 4 || TIMEOUT_CYC < 2) begin : g_bad_params
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] sel;
  logic          sel_vld;
  logic [PW:0]   idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] tmo_cnt;
`endif

  // Scan downward so the requester closest to the pointer is the one that sticks.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW + 1)'(k);
      if (idx >= (PW + 1)'(NM)) idx = idx - (PW + 1)'(NM);
      if (m_req[idx[PW-1:0]]) begin
        sel     = idx[PW-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      bus_a   <= '0;
      bus_d   <= '0;
      bus_we  <= 1'b0;
      bus_rd  <= 1'b0;
      m_ack   <= '0;
      m_err   <= '0;
      m_rdata <= '0;
      busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      m_ack <= '0;
      m_err <= '0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            gnt    <= sel;
            bus_a  <= m_a[{sel, 5'd0} +: 32];
            bus_d  <= m_d[{sel, 5'd0} +: 32];
            bus_we <= m_we[sel];
            bus_rd <= ~m_we[sel];
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          bus_we <= 1'b0;
          bus_rd <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state  <= WAIT;
        end
        WAIT: begin
          if (bus_ready) begin
            m_rdata    <= bus_spo;
            m_ack[gnt] <= 1'b1;
            m_err[gnt] <= bus_irq;
            ptr        <= (gnt == PW'(NM - 1)) ? '0 : gnt + 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
`ifdef ARB_TIMEOUT_EN
          end else if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
            m_rdata    <= '0;
            m_ack[gnt] <= 1'b1;
            m_err[gnt] <= 1'b1;
            ptr        <= (gnt == PW'(NM - 1)) ? '0 : gnt + 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
